// File: rtl/data_sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_arb_pkg
//   Shared definitions for the data SRAM arbiter: read-owner encoding, the
//   width of one SRAM request bundle, and the priority FSM state type.
// -----------------------------------------------------------------------------
package data_sram_arb_pkg;

    // Owner of an outstanding read.
    localparam logic OWN_ES  = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // One SRAM request bundle: en + wen[3:0] + addr[31:0] + wdata[31:0].
    localparam int DSRAM_REQ_WD = 69;

    typedef enum logic {
        PRIO_ES  = 1'b0,
        PRIO_DMA = 1'b1
    } prio_state_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dsram_req_t;

endpackage

// File: rtl/data_sram_arb_prio.sv
// -----------------------------------------------------------------------------
// sram_arb_prio
//   Priority FSM plus starvation counter for the data SRAM arbiter. EXE wins
//   by default; after STARVE_MAX consecutive EXE grants taken while DMA was
//   waiting, DMA is given priority for one slot.
//
//   Ports:
//     clk, resetn        clock, synchronous active-low reset
//     es_req, dma_req    access requests from EXE and DMA
//     es_gnt, dma_gnt    combinational grants (at most one high, 0 in reset)
//
//   STARVE_MAX legal range is 1..15 (4-bit counter).
// -----------------------------------------------------------------------------
module sram_arb_prio
    import data_sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic es_req,
    input  logic dma_req,
    output logic es_gnt,
    output logic dma_gnt
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    prio_state_t state, state_nxt;
    logic [3:0]  starve_cnt, starve_cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, sampled on the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= PRIO_ES;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        es_gnt         = 1'b0;
        dma_gnt        = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;

        if (resetn) begin
            case (state)
                PRIO_ES: begin
                    es_gnt  = es_req;
                    dma_gnt = dma_req && !es_req;
                    if (dma_gnt) begin
                        starve_cnt_nxt = '0;
                    end else if (es_gnt && dma_req) begin
                        // Saturate straight into a forced DMA slot; the
                        // counter therefore never wraps.
                        if (starve_cnt == STARVE_LAST) begin
                            state_nxt      = PRIO_DMA;
                            starve_cnt_nxt = '0;
                        end else begin
                            starve_cnt_nxt = starve_cnt + 4'd1;
                        end
                    end
                end
                PRIO_DMA: begin
                    dma_gnt = dma_req;
                    es_gnt  = es_req && !dma_req;
                    if (dma_gnt) begin
                        starve_cnt_nxt = '0;
                    end
                    // Served, or DMA withdrew its request: EXE regains priority.
                    if (dma_gnt || !dma_req) begin
                        state_nxt = PRIO_ES;
                    end
                end
                default: state_nxt = PRIO_ES;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_arb.sv
// -----------------------------------------------------------------------------
// data_sram_arb
//   Shares the single-port synchronous data SRAM between the EXE stage and a
//   DMA/debug port. One access per cycle; the granted requester's fields are
//   driven onto the SRAM pins, and the owner of each read is remembered so the
//   data returning one cycle later is flagged to the right requester.
//
//   Ports:
//     clk, resetn                       clock, synchronous active-low reset
//     es_req/wen/addr/wdata             EXE request (wen == 0 means read)
//     es_gnt, es_rvalid, es_rdata       EXE accept, read-return valid, data
//     dma_req/wen/addr/wdata            DMA request (wen == 0 means read)
//     dma_gnt, dma_rvalid, dma_rdata    DMA accept, read-return valid, data
//     data_sram_en/wen/addr/wdata       SRAM request pins
//     data_sram_rdata                   SRAM read data, one cycle after read
// -----------------------------------------------------------------------------
module data_sram_arb
    import data_sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        es_req,
    input  logic [3:0]  es_wen,
    input  logic [31:0] es_addr,
    input  logic [31:0] es_wdata,
    output logic        es_gnt,
    output logic        es_rvalid,
    output logic [31:0] es_rdata,

    input  logic        dma_req,
    input  logic [3:0]  dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    dsram_req_t              sel_req;
    logic [DSRAM_REQ_WD-1:0] sram_bus;
    logic                    rd_pend;
    logic                    rd_owner;

    // Grants are already forced low during reset inside the FSM.
    sram_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .resetn  (resetn),
        .es_req  (es_req),
        .dma_req (dma_req),
        .es_gnt  (es_gnt),
        .dma_gnt (dma_gnt)
    );

    // Idle cycles drive an all-zero request so the pins never float stale
    // write data or a stale address.
    always_comb begin
        sel_req = '0;
        if (es_gnt) begin
            sel_req = '{en: 1'b1, wen: es_wen, addr: es_addr, wdata: es_wdata};
        end else if (dma_gnt) begin
            sel_req = '{en: 1'b1, wen: dma_wen, addr: dma_addr, wdata: dma_wdata};
        end
    end

    assign sram_bus = sel_req;
    assign {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} = sram_bus;

    // Any cycle without an accepted read clears rd_pend, so writes and idle
    // cycles never raise rvalid on the following cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_ES;
        end else begin
            rd_pend <= sel_req.en && (sel_req.wen == 4'h0);
            if (sel_req.en && (sel_req.wen == 4'h0)) begin
                rd_owner <= dma_gnt ? OWN_DMA : OWN_ES;
            end
        end
    end

    assign es_rvalid  = resetn && rd_pend && (rd_owner == OWN_ES);
    assign dma_rvalid = resetn && rd_pend && (rd_owner == OWN_DMA);

    // Both requesters see the raw SRAM data; rvalid says whose it is.
    assign es_rdata  = data_sram_rdata;
    assign dma_rdata = data_sram_rdata;

endmodule

// File: tb/tb_data_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_data_sram_arb
//   Self-checking bench for data_sram_arb. Directed scenarios plus a random
//   run compared against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_data_sram_arb;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_req, dma_req;
    logic [3:0]  es_wen, dma_wen;
    logic [31:0] es_addr, es_wdata, dma_addr, dma_wdata;
    logic        es_gnt, es_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] es_rdata, dma_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_sram_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_req          (es_req),
        .es_wen          (es_wen),
        .es_addr         (es_addr),
        .es_wdata        (es_wdata),
        .es_gnt          (es_gnt),
        .es_rvalid       (es_rvalid),
        .es_rdata        (es_rdata),
        .dma_req         (dma_req),
        .dma_wen         (dma_wen),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    // ---------------- behavioural reference model ----------------
    // forced : DMA owns the next slot after being passed over STARVE_MAX times
    // waited : EXE wins taken while DMA was waiting, since DMA last served
    // last_rd: owner of the read accepted last cycle (-1 none, 0 ES, 1 DMA)
    bit m_forced  = 1'b0;
    int m_waited  = 0;
    int m_last_rd = -1;

    typedef struct packed {
        logic        es_gnt;
        logic        dma_gnt;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        es_rv;
        logic        dma_rv;
    } exp_t;

    function automatic exp_t model_expect();
        exp_t e;
        e = '0;
        if (resetn !== 1'b1) return e;
        e.es_rv  = (m_last_rd == 0);
        e.dma_rv = (m_last_rd == 1);
        if (m_forced) begin
            e.dma_gnt = dma_req;
            e.es_gnt  = es_req && !dma_req;
        end else begin
            e.es_gnt  = es_req;
            e.dma_gnt = dma_req && !es_req;
        end
        if (e.es_gnt) begin
            e.en = 1'b1; e.wen = es_wen; e.addr = es_addr; e.wdata = es_wdata;
        end else if (e.dma_gnt) begin
            e.en = 1'b1; e.wen = dma_wen; e.addr = dma_addr; e.wdata = dma_wdata;
        end
        return e;
    endfunction

    // Advance one clock: update the model with this cycle's inputs at the
    // edge, then return at the following falling edge for new stimulus.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        e = model_expect();
        if (resetn !== 1'b1) begin
            m_forced = 1'b0; m_waited = 0; m_last_rd = -1;
        end else begin
            m_last_rd = (e.en && e.wen == 4'h0) ? (e.dma_gnt ? 1 : 0) : -1;
            if (m_forced) begin
                // One slot of DMA priority, used or withdrawn.
                m_forced = 1'b0;
                m_waited = 0;
            end else if (e.dma_gnt) begin
                m_waited = 0;
            end else if (e.es_gnt && dma_req) begin
                m_waited++;
                if (m_waited == STARVE_MAX) begin
                    m_forced = 1'b1;
                    m_waited = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        es_req = 1'b0; es_wen = 4'h0; es_addr = '0; es_wdata = '0;
        dma_req = 1'b0; dma_wen = 4'h0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        es_req = 1'b1; dma_req = 1'b1; resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (es_gnt !== 1'b0) begin n_errors++; $display("FAIL reset es_gnt got %b exp 0", es_gnt); end
            n_checks++; if (dma_gnt !== 1'b0) begin n_errors++; $display("FAIL reset dma_gnt got %b exp 0", dma_gnt); end
            n_checks++; if (data_sram_en !== 1'b0) begin n_errors++; $display("FAIL reset sram_en got %b exp 0", data_sram_en); end
            n_checks++; if ({es_rvalid, dma_rvalid} !== 2'b00) begin n_errors++; $display("FAIL reset rvalid got %b%b exp 00", es_rvalid, dma_rvalid); end
            tick();
        end
        resetn = 1'b1;
        #1;
        n_checks++; if (es_gnt !== 1'b1) begin n_errors++; $display("FAIL post_reset es_gnt got %b exp 1", es_gnt); end
        n_checks++; if (dma_gnt !== 1'b0) begin n_errors++; $display("FAIL post_reset dma_gnt got %b exp 0", dma_gnt); end
        tick();
    endtask

    task automatic test_exe_load();
        do_reset();
        es_req = 1'b1; es_wen = 4'h0; es_addr = 32'h1000;
        #1;
        n_checks++; if (data_sram_en !== 1'b1) begin n_errors++; $display("FAIL load en got %b exp 1", data_sram_en); end
        n_checks++; if (data_sram_addr !== 32'h1000) begin n_errors++; $display("FAIL load addr got %h exp 00001000", data_sram_addr); end
        n_checks++; if (data_sram_wen !== 4'h0) begin n_errors++; $display("FAIL load wen got %h exp 0", data_sram_wen); end
        tick();
        es_req = 1'b0; data_sram_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (es_rvalid !== 1'b1) begin n_errors++; $display("FAIL load es_rvalid got %b exp 1", es_rvalid); end
        n_checks++; if (es_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load es_rdata got %h exp deadbeef", es_rdata); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_errors++; $display("FAIL load dma_rvalid got %b exp 0", dma_rvalid); end
        tick();
    endtask

    task automatic test_exe_store();
        do_reset();
        es_req = 1'b1; es_wen = 4'hF; es_addr = 32'h2004; es_wdata = 32'h12345678;
        #1;
        n_checks++; if (data_sram_wen !== 4'hF) begin n_errors++; $display("FAIL store wen got %h exp f", data_sram_wen); end
        n_checks++; if (data_sram_wdata !== 32'h12345678) begin n_errors++; $display("FAIL store wdata got %h exp 12345678", data_sram_wdata); end
        n_checks++; if (data_sram_en !== 1'b1) begin n_errors++; $display("FAIL store en got %b exp 1", data_sram_en); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if ({es_rvalid, dma_rvalid} !== 2'b00) begin n_errors++; $display("FAIL store rvalid got %b%b exp 00", es_rvalid, dma_rvalid); end
        n_checks++; if (data_sram_en !== 1'b0 || data_sram_addr !== 32'h0 || data_sram_wdata !== 32'h0) begin
            n_errors++; $display("FAIL idle_bus en %b addr %h wdata %h exp 0/0/0", data_sram_en, data_sram_addr, data_sram_wdata);
        end
        tick();
    endtask

    // Both requesting continuously: DMA is served every (STARVE_MAX+1)th cycle.
    task automatic test_starvation();
        bit exp_dma;
        do_reset();
        es_req = 1'b1; es_addr = 32'hA0; dma_req = 1'b1; dma_addr = 32'hB0;
        for (int k = 1; k <= 2 * (STARVE_MAX + 1); k++) begin
            exp_dma = (k % (STARVE_MAX + 1)) == 0;
            #1;
            n_checks++; if (es_gnt !== !exp_dma) begin n_errors++; $display("FAIL starve cyc %0d es_gnt got %b exp %b", k, es_gnt, !exp_dma); end
            n_checks++; if (dma_gnt !== exp_dma) begin n_errors++; $display("FAIL starve cyc %0d dma_gnt got %b exp %b", k, dma_gnt, exp_dma); end
            n_checks++; if (data_sram_addr !== (exp_dma ? 32'hB0 : 32'hA0)) begin n_errors++; $display("FAIL starve cyc %0d addr got %h", k, data_sram_addr); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_alternating_reads();
        do_reset();
        es_req = 1'b1; es_wen = 4'h0; es_addr = 32'h10;
        #1;
        n_checks++; if (data_sram_addr !== 32'h10 || es_gnt !== 1'b1) begin n_errors++; $display("FAIL alt es addr %h gnt %b exp 10/1", data_sram_addr, es_gnt); end
        tick();
        es_req = 1'b0; dma_req = 1'b1; dma_wen = 4'h0; dma_addr = 32'h20; data_sram_rdata = 32'hA5A5_0001;
        #1;
        n_checks++; if (es_rvalid !== 1'b1 || es_rdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL alt es_ret rvalid %b data %h exp 1/a5a50001", es_rvalid, es_rdata); end
        n_checks++; if (dma_rvalid !== 1'b0) begin n_errors++; $display("FAIL alt early dma_rvalid got %b exp 0", dma_rvalid); end
        n_checks++; if (dma_gnt !== 1'b1 || data_sram_addr !== 32'h20) begin n_errors++; $display("FAIL alt dma gnt %b addr %h exp 1/20", dma_gnt, data_sram_addr); end
        tick();
        dma_req = 1'b0; data_sram_rdata = 32'h5A5A_0002;
        #1;
        n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h5A5A_0002) begin n_errors++; $display("FAIL alt dma_ret rvalid %b data %h exp 1/5a5a0002", dma_rvalid, dma_rdata); end
        n_checks++; if (es_rvalid !== 1'b0) begin n_errors++; $display("FAIL alt late es_rvalid got %b exp 0", es_rvalid); end
        tick();
    endtask

    task automatic test_dma_withdraw();
        bit exp_dma;
        do_reset();
        es_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < STARVE_MAX; k++) tick();
        // DMA now has priority; it withdraws and EXE must be served.
        dma_req = 1'b0;
        #1;
        n_checks++; if (es_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_errors++; $display("FAIL withdraw gnt es %b dma %b exp 1/0", es_gnt, dma_gnt); end
        tick();
        // Back in EXE priority with an empty counter: DMA waits a full budget.
        dma_req = 1'b1;
        for (int k = 1; k <= STARVE_MAX + 1; k++) begin
            exp_dma = (k == STARVE_MAX + 1);
            #1;
            n_checks++; if (dma_gnt !== exp_dma) begin n_errors++; $display("FAIL withdraw cyc %0d dma_gnt got %b exp %b", k, dma_gnt, exp_dma); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        es_req = 1'b1; es_wen = 4'h0; es_addr = 32'h30;
        tick();
        idle_inputs();
        resetn = 1'b0;
        #1;
        n_checks++; if (es_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_mid rvalid in reset got %b exp 0", es_rvalid); end
        tick();
        resetn = 1'b1;
        #1;
        n_checks++; if (es_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_mid rvalid after reset got %b exp 0", es_rvalid); end
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        bit   es_hold, dma_hold;
        do_reset();
        es_hold = 1'b0; dma_hold = 1'b0;
        for (int i = 0; i < 800; i++) begin
            // Stall contract: an un-granted request keeps its fields.
            if (!es_hold) begin
                es_req = $urandom_range(0, 3) != 0;
                es_wen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                es_addr = $urandom; es_wdata = $urandom;
            end
            if (!dma_hold) begin
                dma_req = $urandom_range(0, 2) != 0;
                dma_wen = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                dma_addr = $urandom; dma_wdata = $urandom;
            end
            resetn = $urandom_range(0, 63) != 0;
            data_sram_rdata = $urandom;
            #1;
            e = model_expect();
            n_checks++; if (es_gnt !== e.es_gnt) begin n_errors++; $display("FAIL rnd %0d es_gnt got %b exp %b", i, es_gnt, e.es_gnt); end
            n_checks++; if (dma_gnt !== e.dma_gnt) begin n_errors++; $display("FAIL rnd %0d dma_gnt got %b exp %b", i, dma_gnt, e.dma_gnt); end
            n_checks++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {e.en, e.wen, e.addr, e.wdata}) begin
                n_errors++; $display("FAIL rnd %0d sram_bus got %b/%h/%h/%h exp %b/%h/%h/%h", i, data_sram_en, data_sram_wen,
                                     data_sram_addr, data_sram_wdata, e.en, e.wen, e.addr, e.wdata);
            end
            n_checks++; if (es_rvalid !== e.es_rv) begin n_errors++; $display("FAIL rnd %0d es_rvalid got %b exp %b", i, es_rvalid, e.es_rv); end
            n_checks++; if (dma_rvalid !== e.dma_rv) begin n_errors++; $display("FAIL rnd %0d dma_rvalid got %b exp %b", i, dma_rvalid, e.dma_rv); end
            if (e.es_rv || e.dma_rv) begin
                n_checks++; if ({es_rdata, dma_rdata} !== {data_sram_rdata, data_sram_rdata}) begin
                    n_errors++; $display("FAIL rnd %0d rdata got %h/%h exp %h", i, es_rdata, dma_rdata, data_sram_rdata);
                end
            end
            es_hold  = resetn && es_req && !e.es_gnt;
            dma_hold = resetn && dma_req && !e.dma_gnt;
            tick();
        end
        resetn = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        data_sram_rdata = '0;
        @(negedge clk);
        test_reset();
        test_exe_load();
        test_exe_store();
        test_starvation();
        test_alternating_reads();
        test_dma_withdraw();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/data_sram_arb.md
Name: data_sram_arb

Overview:
- Shares the single-port synchronous data SRAM between two requesters: the pipeline EXE stage (loads/stores) and a secondary DMA/debug port.
- Sits between the EXE stage's data SRAM request signals and the physical data_sram_* pins.
- Issues one access per cycle and tracks which requester owns the outstanding read.
- Gives the pipeline priority, with a bounded-starvation guarantee for the DMA port.

Parameters:
STARVE_MAX, 4, max consecutive EXE grants while dma_req is pending before DMA is forced one slot (legal range 1..15)

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
es_req  in  1  EXE access request (load or store), qualified by es_valid upstream
es_wen  in  4  EXE byte write enables; 0 = read
es_addr  in  32  EXE byte address
es_wdata  in  32  EXE write data
es_gnt  out  1  EXE access accepted this cycle; EXE folds this into es_ready_go
es_rvalid  out  1  EXE read data valid on es_rdata
es_rdata  out  32  read data to MEM stage
dma_req  in  1  DMA access request
dma_wen  in  4  DMA byte write enables; 0 = read
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  DMA read data valid on dma_rdata
dma_rdata  out  32  read data to DMA
data_sram_en  out  1  SRAM enable
data_sram_wen  out  4  SRAM byte write enables
data_sram_addr  out  32  SRAM address
data_sram_wdata  out  32  SRAM write data
data_sram_rdata  in  32  SRAM read data, valid 1 cycle after an enabled read

Behaviour:
- Reset: all state registers clear on the clk edge while resetn=0: prio FSM=PRIO_ES, starve_cnt=0, rd_pend=0, rd_owner=0.
- While resetn=0, es_gnt, dma_gnt, data_sram_en, es_rvalid and dma_rvalid are forced 0, combinationally gated.
- Grant is combinational in the request cycle. An access is accepted when req && gnt. At most one grant per cycle.
- Prio FSM, state PRIO_ES:
  - es_gnt = es_req; dma_gnt = dma_req && !es_req.
  - starve_cnt increments when es_gnt && dma_req, and clears when dma_gnt.
  - When starve_cnt == STARVE_MAX-1 and the increment condition holds, go to PRIO_DMA and clear starve_cnt.
- Prio FSM, state PRIO_DMA:
  - dma_gnt = dma_req; es_gnt = es_req && !dma_req.
  - Return to PRIO_ES after any dma_gnt, or if dma_req drops (request withdrawn).
- SRAM drive:
  - data_sram_en = es_gnt || dma_gnt.
  - wen/addr/wdata are muxed from the granted requester.
  - When neither requester is granted, wen=0 and addr/wdata=0.
- Read tracking:
  - On an accepted access with wen==0, set rd_pend=1 and rd_owner to the granted requester (0=ES, 1=DMA).
  - Otherwise clear rd_pend=0.
  - Cycle N+1: es_rvalid = rd_pend && rd_owner==0; dma_rvalid = rd_pend && rd_owner==1.
  - Read latency is exactly 1 cycle. Back-to-back reads from alternating owners are supported every cycle.
  - Writes produce no rvalid.
- es_rdata and dma_rdata both equal data_sram_rdata. Only rvalid distinguishes the owner.
- Stall contract: when es_req && !es_gnt, EXE holds all request fields stable. DMA obeys the same contract.
- Simultaneous requests in PRIO_ES: EXE wins. In PRIO_DMA: DMA wins. The loser sees gnt=0 and retries next cycle.
- Reset mid-read: rd_pend clears, so no rvalid appears in the cycle after reset is asserted.
- Starve counter width is 4 bits; it never wraps, because it saturates into the PRIO_DMA transition.

Decomposition:
- Shared header (mycpu.h) holds:
  - owner encoding: OWN_ES=0, OWN_DMA=1;
  - SRAM request bus width define DSRAM_REQ_WD=69 (en + wen + addr + wdata);
  - FSM state encodings PRIO_ES=0, PRIO_DMA=1.
- One sub-module, sram_arb_prio: priority FSM plus starvation counter. Inputs es_req, dma_req, resetn. Outputs es_gnt, dma_gnt.
- Muxing and read tracking stay in data_sram_arb.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with es_req=dma_req=1 -> es_gnt=dma_gnt=data_sram_en=0; after release, PRIO_ES and es_gnt=1.
2. EXE load: es_req=1, es_wen=0, es_addr=0x1000 for one cycle; SRAM returns 0xDEADBEEF -> data_sram_en=1 and data_sram_addr=0x1000 in cycle N; es_rvalid=1 and es_rdata=0xDEADBEEF in N+1; dma_rvalid=0.
3. EXE store: es_wen=0xF, es_wdata=0x12345678 -> data_sram_wen=0xF and data_sram_wdata=0x12345678 same cycle; no rvalid in N+1.
4. Starvation, STARVE_MAX=4: es_req and dma_req held at 1 -> es_gnt for 4 cycles, dma_gnt in cycle 5, es_gnt in cycles 6-9, dma_gnt in cycle 10; the pattern repeats.
5. Alternating reads: ES read 0x10 in cycle N, DMA read 0x20 in N+1 -> es_rvalid in N+1, dma_rvalid in N+2, each carrying that cycle's data_sram_rdata.
6. DMA withdraws in PRIO_DMA: force PRIO_DMA, then drop dma_req with es_req=1 -> es_gnt=1 that cycle; FSM returns to PRIO_ES; starve_cnt=0.
